// File: rtl/hyperram_wb_arbiter.sv
// Purpose: two-master request arbiter onto a single Wishbone master port for HyperRAM; optional watchdog via HYPERRAM_ARB_TIMEOUT_EN.
// Latency: valid sampled at edge T gives cyc/stb from T+1; ready pulses on the edge after ack, then DONE -> IDLE.
// Backpressure: masters hold valid until ready; one transaction at a time, ack outside a bus phase is ignored.
module hyperram_wb_arbiter #(
    parameter logic [7:0]  ADDR_BASE      = 8'h30,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        timeout_o
);

    typedef enum logic [2:0] {IDLE, BUS0, BUS1, DONE0, DONE1} state_t;

    // Reject an out-of-range watchdog limit at elaboration time.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be within 1..65535");
        end
    endgenerate

    state_t      state;
    logic        last_m1;
    logic        elig0, elig1, pick_m1;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        bus_done;
    logic [31:0] bus_dat;

    assign elig0     = m0_valid && (m0_addr[31:24] == ADDR_BASE);
    assign elig1     = m1_valid && (m1_addr[31:24] == ADDR_BASE);
    // Round-robin: m1 wins only if m0 is not asking or m0 was served last.
    assign pick_m1   = elig1 && (!elig0 || !last_m1);
    assign req_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign req_wdata = pick_m1 ? m1_wdata : m0_wdata;
    assign req_wstrb = pick_m1 ? m1_wstrb : m0_wstrb;

`ifdef HYPERRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;
    logic        bus_to;

    // A bus phase ends on ack, or with a poison word once the watchdog limit is hit.
    always_comb begin
        bus_done = wbm_ack_i;
        bus_dat  = wbm_dat_i;
        bus_to   = 1'b0;
        if (!wbm_ack_i && (wd_cnt == TO_LAST)) begin
            bus_done = 1'b1;
            bus_dat  = 32'hDEAD_BEEF;
            bus_to   = 1'b1;
        end
    end
`else
    // Without the watchdog a bus phase only ends on ack.
    always_comb begin
        bus_done = wbm_ack_i;
        bus_dat  = wbm_dat_i;
    end
    assign timeout_o = 1'b0;
`endif

    // Arbitration FSM with all master-facing and Wishbone outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_m1    <= 1'b1;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 4'h0;
            wbm_addr_o <= 32'h0;
            wbm_dat_o  <= 32'h0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= 32'h0;
            m1_rdata   <= 32'h0;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
            timeout_o  <= 1'b0;
            wd_cnt     <= 16'h0;
`endif
        end else begin
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        state      <= pick_m1 ? BUS1 : BUS0;
                        last_m1    <= pick_m1;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        wbm_addr_o <= req_addr;
                        wbm_dat_o  <= req_wdata;
                        wbm_we_o   <= |req_wstrb;
                        wbm_sel_o  <= (|req_wstrb) ? req_wstrb : 4'hF;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
                        wd_cnt     <= 16'h0;
`endif
                    end
                end
                BUS0, BUS1: begin
                    if (bus_done) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
                        timeout_o <= bus_to;
`endif
                        if (state == BUS1) begin
                            m1_rdata <= bus_dat;
                            m1_ready <= 1'b1;
                            state    <= DONE1;
                        end else begin
                            m0_rdata <= bus_dat;
                            m0_ready <= 1'b1;
                            state    <= DONE0;
                        end
                    end
`ifdef HYPERRAM_ARB_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt + 16'h1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_wb_arbiter.sv
// Purpose: directed checks of the HyperRAM Wishbone arbiter with a simple acking slave.
// Latency: slave acks a programmable number of cycles after stb rises.
// Backpressure: masters hold valid until ready unless a vector drops it early.
`timescale 1ns/1ps
module tb_hyperram_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        timeout_o;

    logic        slv_ack = 1'b0;
    logic [31:0] slv_dat = 32'h0;
    logic [31:0] slv_key = 32'h0;
    logic        force_ack = 1'b0;
    bit          ack_en = 1'b1;
    int          ack_delay = 3;
    int          slv_cnt = 0;

    int checks = 0;
    int errors = 0;

    logic [31:0] grant_q[$];
    bit          mon_en = 1'b0;
    int          low_run = 100;

    always #5 clk = ~clk;

    assign wbm_ack_i = slv_ack | force_ack;
    assign wbm_dat_i = slv_dat;

    hyperram_wb_arbiter #(.ADDR_BASE(8'h30), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave: acks after ack_delay stb cycles, returning slv_key ^ address.
    always @(posedge clk) begin
        #2;
        if (wbm_cyc_o && wbm_stb_o && ack_en && !slv_ack) begin
            slv_cnt++;
            if (slv_cnt >= ack_delay) begin
                slv_ack = 1'b1;
                slv_dat = slv_key ^ wbm_addr_o;
                slv_cnt = 0;
            end
        end else begin
            slv_ack = 1'b0;
            slv_cnt = 0;
        end
    end

    // Grant monitor: logs each new bus cycle and the idle gap before it.
    always @(negedge clk) begin
        if (wbm_cyc_o) begin
            if (low_run > 0 && mon_en) begin
                grant_q.push_back(wbm_addr_o);
                check("bus_gap", 32'(low_run >= 2), 32'd1);
            end
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic set_m(input bit m, input bit v, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd);
        if (m) begin
            m1_valid = v; m1_addr = a; m1_wstrb = s; m1_wdata = wd;
        end else begin
            m0_valid = v; m0_addr = a; m0_wstrb = s; m0_wdata = wd;
        end
    endtask

    task automatic xfer(input bit m, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input bit drop_early, input string tag);
        bit seen;
        int other;
        seen  = 1'b0;
        other = 0;
        @(negedge clk);
        set_m(m, 1'b1, a, s, wd);
        @(negedge clk);
        check({tag, "_cyc"},  32'(wbm_cyc_o), 32'd1);
        check({tag, "_stb"},  32'(wbm_stb_o), 32'd1);
        check({tag, "_we"},   32'(wbm_we_o), (s != 4'h0) ? 32'd1 : 32'd0);
        check({tag, "_sel"},  32'(wbm_sel_o), (s != 4'h0) ? 32'(s) : 32'hF);
        check({tag, "_addr"}, wbm_addr_o, a);
        check({tag, "_dat"},  wbm_dat_o, wd);
        if (drop_early) set_m(m, 1'b0, a, s, wd);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (m ? m0_ready : m1_ready) other++;
            if (m ? m1_ready : m0_ready) seen = 1'b1;
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
        check({tag, "_rdata"}, m ? m1_rdata : m0_rdata, slv_key ^ a);
        check({tag, "_cyc_off"}, 32'(wbm_cyc_o), 32'd0);
        @(negedge clk);
        set_m(m, 1'b0, a, s, wd);
        check({tag, "_rdy_pulse"}, 32'(m ? m1_ready : m0_ready), 32'd0);
        @(negedge clk);
        check({tag, "_no_regrant"}, 32'(wbm_cyc_o), 32'd0);
        check({tag, "_other_rdy"}, 32'(other), 32'd0);
    endtask

    task automatic both_xfer(input logic [31:0] a0, input logic [31:0] a1, input string tag);
        bit d0, d1;
        d0 = 1'b0;
        d1 = 1'b0;
        @(negedge clk);
        set_m(1'b0, 1'b1, a0, 4'h0, 32'h0);
        set_m(1'b1, 1'b1, a1, 4'h0, 32'h0);
        for (int i = 0; i < 60 && !(d0 && d1); i++) begin
            @(negedge clk);
            if (m0_ready) begin
                d0 = 1'b1; m0_valid = 1'b0;
                check({tag, "_m0_rdata"}, m0_rdata, slv_key ^ a0);
            end
            if (m1_ready) begin
                d1 = 1'b1; m1_valid = 1'b0;
                check({tag, "_m1_rdata"}, m1_rdata, slv_key ^ a1);
            end
        end
        check({tag, "_both_done"}, {30'b0, d0, d1}, 32'd3);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check({tag, "_cyc"}, 32'(wbm_cyc_o), 32'd0);
        check({tag, "_stb"}, 32'(wbm_stb_o), 32'd0);
        check({tag, "_rdy"}, {30'b0, m0_ready, m1_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_rdy_hold"}, {30'b0, m0_ready, m1_ready}, 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        int cyc_n, rdy_n, to_n, bad_n;
        logic [31:0] got;
        resetn = 1'b0;
        set_m(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        check("rst_cyc_stb_we", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        check("rst_sel", 32'(wbm_sel_o), 32'd0);
        check("rst_addr", wbm_addr_o, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        check("rst_ready", {30'b0, m0_ready, m1_ready}, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // m0 read, slave returns 32'h1234_5678 (key ^ 32'h3000_0010)
        slv_key = 32'h2234_5668;
        xfer(1'b0, 32'h3000_0010, 4'h0, 32'h0, 1'b0, "rd_m0");
        check("rd_m0_const", m0_rdata, 32'h1234_5678);

        // m1 partial write, valid dropped right after the grant
        slv_key = 32'h0F0F_0F0F;
        xfer(1'b1, 32'h3000_0004, 4'b0011, 32'hAABB_CCDD, 1'b1, "wr_m1");
        check("m0_rdata_hold", m0_rdata, 32'h1234_5678);

        // Stray ack while idle must be ignored
        force_ack = 1'b1;
        bad_n = 0;
        repeat (3) begin
            @(negedge clk);
            if (wbm_cyc_o || m0_ready || m1_ready) bad_n++;
        end
        force_ack = 1'b0;
        check("stray_ack", 32'(bad_n), 32'd0);
        check("stray_ack_rdata", m1_rdata, 32'h0F0F_0F0F ^ 32'h3000_0004);

        // Request outside the HyperRAM window
        @(negedge clk);
        set_m(1'b0, 1'b1, 32'h0300_0000, 4'h0, 32'h0);
        bad_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (wbm_cyc_o || m0_ready) bad_n++;
        end
        m0_valid = 1'b0;
        check("inelig", 32'(bad_n), 32'd0);

        // Simultaneous requests twice: m0, m1, m0, m1
        grant_q.delete();
        mon_en    = 1'b1;
        ack_delay = 2;
        slv_key   = 32'h5555_0000;
        both_xfer(32'h3000_0100, 32'h3000_0200, "pair1");
        both_xfer(32'h3000_0300, 32'h3000_0400, "pair2");
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("grant_cnt", 32'(grant_q.size()), 32'd4);
        if (grant_q.size() == 4) begin
            check("grant0", grant_q[0], 32'h3000_0100);
            check("grant1", grant_q[1], 32'h3000_0200);
            check("grant2", grant_q[2], 32'h3000_0300);
            check("grant3", grant_q[3], 32'h3000_0400);
        end

        // Slave never acks
        ack_en = 1'b0;
        @(negedge clk);
        set_m(1'b0, 1'b1, 32'h3000_0020, 4'h0, 32'h0);
        cyc_n = 0; rdy_n = 0; to_n = 0; got = 32'h0;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wbm_cyc_o) cyc_n++;
            if (timeout_o) to_n++;
            if (m0_ready) begin
                rdy_n++;
                got = m0_rdata;
                m0_valid = 1'b0;
            end
        end
        check("to_cyc_cycles", 32'(cyc_n), 32'd8);
        check("to_ready_pulses", 32'(rdy_n), 32'd1);
        check("to_timeout_pulses", 32'(to_n), 32'd1);
        check("to_rdata", got, 32'hDEAD_BEEF);
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (wbm_cyc_o) cyc_n++;
            if (timeout_o) to_n++;
            if (m0_ready) rdy_n++;
        end
        check("hang_cyc_cycles", 32'(cyc_n), 32'd1000);
        check("hang_ready", 32'(rdy_n), 32'd0);
        check("hang_timeout", 32'(to_n), 32'd0);
        pulse_reset("hang_rst");
`endif

        // Reset in the middle of a bus cycle, then normal service
        @(negedge clk);
        set_m(1'b0, 1'b1, 32'h3000_0030, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
        pulse_reset("mid_rst");
        check("mid_rst_rdata", m0_rdata, 32'h0);
        ack_en    = 1'b1;
        ack_delay = 3;
        slv_key   = 32'h0102_0304;
        xfer(1'b0, 32'h3000_0040, 4'hF, 32'h0BAD_F00D, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
